// File: rtl/pc_sequencer.sv
// Fetch PC sequencer + IF/ID register: 1-cycle fetch->IF/ID latency, 1 instr/cycle.
// Stall holds PC and IF/ID; a redirect seen under stall is parked and applied once stall drops.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        flush,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic [3:0]  if_id_pc_hi,
  output logic [27:0] if_id_jidx,
  output logic        addr_err,
  output logic [31:0] badvaddr
);

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        vld_q, vld_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic [31:0] bad_q, bad_d;

  logic        cand_vld;
  logic [31:0] cand;
  logic        misalign;

  // A fresh redirect always beats the parked one.
  assign cand_vld = redirect_valid | ((state_q == PEND) & ~stall);
  assign cand     = redirect_valid ? redirect_target : pend_q;
  assign misalign = cand_vld & (cand[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    vld_d   = vld_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    instr_d = instr_q;
    err_d   = 1'b0;
    bad_d   = bad_q;

    if (flush || misalign) begin
      if (!flush) begin
        err_d = 1'b1;
        bad_d = cand;
      end
      pc_d    = EXC_VECTOR;
      vld_d   = 1'b0;
      ipc_d   = 32'h0;
      ipc4_d  = 32'h0;
      instr_d = 32'h0;
      pend_d  = 32'h0;
      state_d = RUN;
    end else if (stall) begin
      if (redirect_valid) begin
        pend_d  = redirect_target;
        state_d = PEND;
      end
    end else begin
      state_d = RUN;
      vld_d   = 1'b1;
      ipc_d   = pc_q;
      ipc4_d  = pc_q + 32'd4;
      instr_d = imem_rdata;
      if (cand_vld) begin
        pc_d   = cand;
        pend_d = 32'h0;
        // Without a delay slot the instruction fetched alongside the redirect is squashed.
        if (!DELAY_SLOT) begin
          vld_d   = 1'b0;
          ipc_d   = 32'h0;
          ipc4_d  = 32'h0;
          instr_d = 32'h0;
        end
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= 32'h0;
      vld_q   <= 1'b0;
      ipc_q   <= 32'h0;
      ipc4_q  <= 32'h0;
      instr_q <= 32'h0;
      err_q   <= 1'b0;
      bad_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      vld_q   <= vld_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      bad_q   <= bad_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_valid = vld_q;
  assign if_id_pc    = ipc_q;
  assign if_id_pc4   = ipc4_q;
  assign if_id_instr = instr_q;
  assign if_id_pc_hi = ipc4_q[31:28];
  assign if_id_jidx  = {instr_q[25:0], 2'b00};
  assign addr_err    = err_q;
  assign badvaddr    = bad_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (with and without delay slot) share stimulus
// and are compared every cycle against a simple behavioural fetch model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] EXC    = 32'h0000_0180;

  logic        clk = 1'b0;
  logic        rst, stall, rv, fl;
  logic [31:0] rt;

  logic [31:0] o_addr [2];
  logic [31:0] o_rdata[2];
  logic        o_vld  [2];
  logic [31:0] o_ipc  [2];
  logic [31:0] o_ipc4 [2];
  logic [31:0] o_instr[2];
  logic [3:0]  o_hi   [2];
  logic [27:0] o_jidx [2];
  logic        o_err  [2];
  logic [31:0] o_bad  [2];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Model state; index k of the IF/ID arrays is the DELAY_SLOT value of that instance.
  logic [31:0] m_pc, m_pend, m_bad;
  bit          m_pend_vld, m_err;
  bit          m_vld  [2];
  logic [31:0] m_ipc  [2];
  logic [31:0] m_ipc4 [2];
  logic [31:0] m_instr[2];

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'h4800_0010;
  endfunction

  assign o_rdata[0] = imem(o_addr[0]);
  assign o_rdata[1] = imem(o_addr[1]);

  pc_sequencer #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC), .DELAY_SLOT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(rv), .redirect_target(rt),
    .flush(fl), .imem_addr(o_addr[0]), .imem_rdata(o_rdata[0]), .if_id_valid(o_vld[0]),
    .if_id_pc(o_ipc[0]), .if_id_pc4(o_ipc4[0]), .if_id_instr(o_instr[0]),
    .if_id_pc_hi(o_hi[0]), .if_id_jidx(o_jidx[0]), .addr_err(o_err[0]), .badvaddr(o_bad[0]));

  pc_sequencer #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC), .DELAY_SLOT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(rv), .redirect_target(rt),
    .flush(fl), .imem_addr(o_addr[1]), .imem_rdata(o_rdata[1]), .if_id_valid(o_vld[1]),
    .if_id_pc(o_ipc[1]), .if_id_pc4(o_ipc4[1]), .if_id_instr(o_instr[1]),
    .if_id_pc_hi(o_hi[1]), .if_id_jidx(o_jidx[1]), .addr_err(o_err[1]), .badvaddr(o_bad[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bubble(input int k);
    m_vld[k] = 0; m_ipc[k] = 0; m_ipc4[k] = 0; m_instr[k] = 0;
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_pend = 0; m_pend_vld = 0; m_err = 0; m_bad = 0;
    bubble(0);
    bubble(1);
  endtask

  task automatic model_step();
    logic [31:0] target;
    bit          take;
    target = rv ? rt : m_pend;
    take   = rv || (m_pend_vld && !stall);
    if (rst) begin
      model_reset();
    end else if (fl || (take && (target % 4) != 0)) begin
      m_err = !fl;
      if (!fl) m_bad = target;
      m_pc = EXC;
      m_pend_vld = 0;
      bubble(0);
      bubble(1);
    end else begin
      m_err = 0;
      if (stall) begin
        if (rv) begin
          m_pend_vld = 1;
          m_pend = rt;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          m_vld[k] = 1; m_ipc[k] = m_pc; m_ipc4[k] = m_pc + 4; m_instr[k] = imem(m_pc);
        end
        if (take) bubble(0);
        m_pc = take ? target : m_pc + 4;
        m_pend_vld = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ds%0d.imem_addr", k), o_addr[k], m_pc);
      chk($sformatf("ds%0d.valid", k), {31'b0, o_vld[k]}, {31'b0, m_vld[k]});
      chk($sformatf("ds%0d.pc", k), o_ipc[k], m_ipc[k]);
      chk($sformatf("ds%0d.pc4", k), o_ipc4[k], m_ipc4[k]);
      chk($sformatf("ds%0d.instr", k), o_instr[k], m_instr[k]);
      chk($sformatf("ds%0d.pc_hi", k), {28'b0, o_hi[k]}, m_ipc4[k] >> 28);
      chk($sformatf("ds%0d.jidx", k), {4'b0, o_jidx[k]}, (m_instr[k] % 32'h0400_0000) * 4);
      chk($sformatf("ds%0d.addr_err", k), {31'b0, o_err[k]}, {31'b0, m_err});
      chk($sformatf("ds%0d.badvaddr", k), o_bad[k], m_bad);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] frozen;
    rst = 1; stall = 0; rv = 0; rt = 0; fl = 0;
    #1;
    model_reset();
    check_all();
    chk("reset_addr", o_addr[1], 32'h0);
    chk("reset_jidx", {4'b0, o_jidx[1]}, 32'h0);
    #3 rst = 0;

    // Sequential fetch from reset
    cyc();
    chk("seq_addr1", o_addr[1], 32'h4);
    chk("first_pc", o_ipc[1], 32'h0);
    chk("first_pc4", o_ipc4[1], 32'h4);
    chk("first_valid", {31'b0, o_vld[1]}, 32'h1);
    cyc();
    chk("seq_addr2", o_addr[1], 32'h8);

    // Redirect to 0x100 from pc 0x8
    rv = 1; rt = 32'h100;
    cyc();
    rv = 0;
    chk("redir_addr", o_addr[1], 32'h100);
    chk("ds1_slot_pc", o_ipc[1], 32'h8);
    chk("ds0_bubble_vld", {31'b0, o_vld[0]}, 32'h0);
    chk("ds0_bubble_instr", o_instr[0], 32'h0);
    cyc();
    chk("target_in_ifid", o_ipc[1], 32'h100);

    // Jump-target split
    rv = 1; rt = 32'h4000_0000;
    cyc();
    rv = 0;
    cyc();
    chk("split_instr", o_instr[1], 32'h0800_0010);
    chk("split_pc_hi", {28'b0, o_hi[1]}, 32'h4);
    chk("split_jidx", {4'b0, o_jidx[1]}, 32'h40);

    // Redirect pulse during a 3-cycle stall
    frozen = o_addr[1];
    stall = 1; rv = 1; rt = 32'h200;
    cyc();
    rv = 0;
    chk("stall_hold1", o_addr[1], frozen);
    cyc();
    chk("stall_hold2", o_addr[1], frozen);
    cyc();
    chk("stall_hold3", o_addr[1], frozen);
    stall = 0;
    cyc();
    chk("pend_apply", o_addr[1], 32'h200);

    // Second redirect during stall overwrites the pending one
    stall = 1; rv = 1; rt = 32'h200;
    cyc();
    rt = 32'h300;
    cyc();
    rv = 0;
    cyc();
    stall = 0;
    cyc();
    chk("pend_overwrite", o_addr[1], 32'h300);

    // Misaligned redirect
    rv = 1; rt = 32'h102;
    cyc();
    rv = 0;
    chk("mis_err", {31'b0, o_err[1]}, 32'h1);
    chk("mis_bad", o_bad[1], 32'h102);
    chk("mis_addr", o_addr[1], 32'h180);
    chk("mis_vld", {31'b0, o_vld[1]}, 32'h0);
    cyc();
    chk("mis_err_pulse", {31'b0, o_err[1]}, 32'h0);

    // Flush beats stall and redirect and drops the pending target
    stall = 1; rv = 1; rt = 32'h400; fl = 1;
    cyc();
    rv = 0; fl = 0;
    chk("flush_addr", o_addr[1], 32'h180);
    cyc();
    stall = 0;
    cyc();
    chk("flush_no_pend", o_addr[1], 32'h184);

    // 32-bit wrap
    rv = 1; rt = 32'hFFFF_FFF8;
    cyc();
    rv = 0;
    cyc();
    cyc();
    chk("wrap_addr", o_addr[1], 32'h0);

    // Asynchronous reset while a redirect is pending
    stall = 1; rv = 1; rt = 32'h500;
    cyc();
    rv = 0;
    #2 rst = 1;
    #1;
    model_reset();
    check_all();
    chk("arst_addr", o_addr[1], RST_PC);
    chk("arst_vld", {31'b0, o_vld[1]}, 32'h0);
    #1 rst = 0; stall = 0;
    cyc();
    chk("arst_no_pend", o_addr[1], 32'h4);

    // Randomized traffic
    repeat (400) begin
      stall = ($urandom_range(0, 9) < 3);
      rv    = ($urandom_range(0, 9) < 2);
      fl    = ($urandom_range(0, 39) == 0);
      rt    = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 3) == 0) rt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1;
        #1;
        model_reset();
        check_all();
        #1 rst = 0;
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
